// File: rtl/score_keeper.sv
// Game score accumulator: event awards, ghost-combo multiplier, 4-digit saturation,
// high-score tracking and a once-per-game extra-life pulse.
package game_pkg;
    typedef enum logic [1:0] {
        GAME_MODE_LOADING = 2'd0,
        GAME_MODE_READY   = 2'd1,
        GAME_MODE_PLAY    = 2'd2,
        GAME_MODE_FAIL    = 2'd3
    } game_mode_t;
endpackage

module score_keeper
    import game_pkg::*;
#(
    parameter int unsigned SCORE_MAX      = 9999,
    parameter int unsigned PELLET_PTS     = 10,
    parameter int unsigned POWER_PTS      = 50,
    parameter int unsigned FRUIT_PTS      = 100,
    parameter int unsigned GHOST_BASE_PTS = 200,
    parameter int unsigned EXTRA_LIFE_AT  = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  game_mode_t  MODE,
    input  logic        pellet_eaten,
    input  logic        power_eaten,
    input  logic        fruit_eaten,
    input  logic        ghost_eaten,
    input  logic        power_expired,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic [15:0] ghost_pts,
    output logic        extra_life,
    output logic        new_high
);

    logic [1:0]  combo, combo_used, combo_nxt;
    logic        life_given;
    game_mode_t  prev_mode;
    logic        playing, ready_entry, life_hit;
    logic [15:0] ghost_award, score_nxt;
    logic [16:0] award_sum, raw_sum;

    assign playing     = (MODE != GAME_MODE_LOADING) && (MODE != GAME_MODE_READY) &&
                         (MODE != GAME_MODE_FAIL);
    assign ready_entry = (MODE == GAME_MODE_READY) && (prev_mode != GAME_MODE_READY);

    // A power pellet eaten alongside a ghost restarts the chain for that same ghost.
    assign combo_used  = power_eaten ? 2'd0 : combo;
    assign ghost_award = 16'(GHOST_BASE_PTS << combo_used);

    always_comb begin
        combo_nxt = combo;
        if (power_eaten)
            combo_nxt = ghost_eaten ? 2'd1 : 2'd0;
        else if (power_expired)
            combo_nxt = 2'd0;
        else if (ghost_eaten && combo != 2'd3)
            combo_nxt = combo + 2'd1;
    end

    assign award_sum = (pellet_eaten ? 17'(PELLET_PTS) : 17'd0)
                     + (power_eaten  ? 17'(POWER_PTS)  : 17'd0)
                     + (fruit_eaten  ? 17'(FRUIT_PTS)  : 17'd0)
                     + (ghost_eaten  ? {1'b0, ghost_award} : 17'd0);
    assign raw_sum   = {1'b0, score} + award_sum;
    assign score_nxt = (raw_sum > 17'(SCORE_MAX)) ? 16'(SCORE_MAX) : raw_sum[15:0];
    assign life_hit  = !life_given && (score < 16'(EXTRA_LIFE_AT)) &&
                       (score_nxt >= 16'(EXTRA_LIFE_AT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score      <= '0;
            high_score <= '0;
            ghost_pts  <= '0;
            extra_life <= 1'b0;
            new_high   <= 1'b0;
            combo      <= '0;
            life_given <= 1'b0;
            prev_mode  <= GAME_MODE_LOADING;
        end else begin
            prev_mode  <= MODE;
            extra_life <= 1'b0;
            if (score > high_score) begin
                high_score <= score;
                new_high   <= 1'b1;
            end
            // A fresh game wipes per-game state; the high score survives.
            if (ready_entry) begin
                score      <= '0;
                combo      <= '0;
                ghost_pts  <= '0;
                life_given <= 1'b0;
                new_high   <= 1'b0;
            end else if (playing) begin
                score <= score_nxt;
                combo <= combo_nxt;
                if (ghost_eaten)
                    ghost_pts <= ghost_award;
                if (life_hit) begin
                    extra_life <= 1'b1;
                    life_given <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: awards, combo chain, saturation, extra life,
// high score across games and asynchronous reset.
module tb_score_keeper;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    game_mode_t  mode = GAME_MODE_LOADING;
    logic        pe = 1'b0, pw = 1'b0, fr = 1'b0, gh = 1'b0, px = 1'b0;
    logic [15:0] score, high_score, ghost_pts;
    logic        extra_life, new_high;

    int checks = 0;
    int errors = 0;

    score_keeper dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .MODE          (mode),
        .pellet_eaten  (pe),
        .power_eaten   (pw),
        .fruit_eaten   (fr),
        .ghost_eaten   (gh),
        .power_expired (px),
        .score         (score),
        .high_score    (high_score),
        .ghost_pts     (ghost_pts),
        .extra_life    (extra_life),
        .new_high      (new_high)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One-cycle event pulse; returns at the falling edge after the sampling edge.
    task automatic ev(input logic p, input logic w, input logic f, input logic g, input logic x);
        @(negedge clk);
        pe = p; pw = w; fr = f; gh = g; px = x;
        @(negedge clk);
        pe = 1'b0; pw = 1'b0; fr = 1'b0; gh = 1'b0; px = 1'b0;
    endtask

    task automatic set_mode(input game_mode_t m);
        @(negedge clk);
        mode = m;
        @(negedge clk);
    endtask

    task automatic new_game();
        set_mode(GAME_MODE_FAIL);
        set_mode(GAME_MODE_READY);
        set_mode(GAME_MODE_PLAY);
    endtask

    initial begin
        int exp_score;
        int pulses;
        int gp[5];
        gp = '{200, 400, 800, 1600, 1600};

        #12;
        check("rst_score", 32'(score), 0);
        check("rst_high", 32'(high_score), 0);
        check("rst_ghost", 32'(ghost_pts), 0);
        check("rst_life", 32'(extra_life), 0);
        check("rst_newhigh", 32'(new_high), 0);
        rst_n = 1'b1;

        // Game 1: pellets in 10-point steps
        set_mode(GAME_MODE_PLAY);
        for (int i = 1; i <= 7; i++) begin
            ev(1, 0, 0, 0, 0);
            check("pellet_step", 32'(score), 32'(i * 10));
        end
        @(negedge clk);
        check("high_70", 32'(high_score), 70);
        check("newhigh_set", 32'(new_high), 1);

        set_mode(GAME_MODE_READY);
        check("ready_score", 32'(score), 0);
        check("ready_high_kept", 32'(high_score), 70);
        check("ready_newhigh_clr", 32'(new_high), 0);

        // Game 2: power pellet then a 5-ghost chain
        set_mode(GAME_MODE_PLAY);
        ev(0, 1, 0, 0, 0);
        check("power_score", 32'(score), 50);
        exp_score = 50;
        for (int k = 0; k < 5; k++) begin
            ev(0, 0, 0, 1, 0);
            exp_score += gp[k];
            check("ghost_pts_chain", 32'(ghost_pts), 32'(gp[k]));
            check("ghost_score", 32'(score), 32'(exp_score));
        end
        check("chain_total", 32'(score), 4650);
        check("no_life_below", 32'(extra_life), 0);
        @(negedge clk);
        check("high_4650", 32'(high_score), 4650);

        // Events outside playing are ignored, including the ghost popup
        set_mode(GAME_MODE_FAIL);
        ev(1, 0, 0, 0, 0);
        ev(0, 0, 0, 1, 0);
        check("fail_score_hold", 32'(score), 4650);
        check("fail_ghost_hold", 32'(ghost_pts), 1600);

        set_mode(GAME_MODE_READY);
        check("ready2_score", 32'(score), 0);
        check("ready2_ghost", 32'(ghost_pts), 0);
        check("ready2_high", 32'(high_score), 4650);
        check("ready2_newhigh", 32'(new_high), 0);

        // Game 3: lower score keeps prior high; combo corner cases
        set_mode(GAME_MODE_PLAY);
        repeat (3) ev(0, 0, 1, 0, 0);
        check("fruit_300", 32'(score), 300);
        @(negedge clk);
        check("high_kept_4650", 32'(high_score), 4650);
        check("newhigh_stays0", 32'(new_high), 0);

        ev(0, 1, 0, 1, 0);
        check("pw_gh_score", 32'(score), 550);
        check("pw_gh_pts", 32'(ghost_pts), 200);
        ev(0, 0, 0, 1, 0);
        check("after_pw_gh_pts", 32'(ghost_pts), 400);
        check("after_pw_gh_score", 32'(score), 950);
        ev(0, 0, 0, 1, 1);
        check("exp_gh_pts", 32'(ghost_pts), 800);
        check("exp_gh_score", 32'(score), 1750);
        ev(0, 0, 0, 1, 0);
        check("after_exp_pts", 32'(ghost_pts), 200);
        check("after_exp_score", 32'(score), 1950);
        ev(0, 1, 0, 0, 1);
        ev(0, 0, 0, 1, 0);
        check("pw_exp_ghost", 32'(ghost_pts), 200);
        check("pw_exp_score", 32'(score), 2200);

        // Approach the extra-life threshold and hit it exactly
        repeat (27) ev(0, 0, 1, 0, 0);
        repeat (9) ev(1, 0, 0, 0, 0);
        check("score_4990", 32'(score), 4990);
        check("life_not_yet", 32'(extra_life), 0);
        ev(1, 0, 0, 0, 0);
        check("score_5000", 32'(score), 5000);
        check("life_pulse", 32'(extra_life), 1);
        @(negedge clk);
        check("life_one_cycle", 32'(extra_life), 0);
        ev(1, 0, 0, 0, 0);
        check("life_no_repeat", 32'(extra_life), 0);

        // Game 4: extra life re-arms, then saturation
        new_game();
        check("game4_score", 32'(score), 0);
        pulses = 0;
        for (int i = 0; i < 49; i++) begin
            ev(0, 0, 1, 0, 0);
            if (extra_life) pulses++;
        end
        check("early_pulses", 32'(pulses), 0);
        ev(0, 0, 1, 0, 0);
        check("life_rearmed", 32'(extra_life), 1);
        for (int i = 0; i < 49; i++) begin
            ev(0, 0, 1, 0, 0);
            if (extra_life) pulses++;
        end
        repeat (9) ev(1, 0, 0, 0, 0);
        check("late_pulses", 32'(pulses), 0);
        check("score_9990", 32'(score), 9990);
        ev(1, 0, 1, 0, 0);
        check("saturate", 32'(score), 9999);
        ev(0, 0, 1, 0, 0);
        check("saturate_hold", 32'(score), 9999);
        @(negedge clk);
        check("high_9999", 32'(high_score), 9999);

        // Async reset mid-game
        new_game();
        repeat (12) ev(0, 0, 1, 0, 0);
        repeat (3) ev(1, 0, 0, 0, 0);
        check("score_1230", 32'(score), 1230);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_score", 32'(score), 0);
        check("arst_high", 32'(high_score), 0);
        check("arst_ghost", 32'(ghost_pts), 0);
        check("arst_newhigh", 32'(new_high), 0);
        check("arst_life", 32'(extra_life), 0);
        #1 rst_n = 1'b1;
        ev(1, 0, 0, 0, 0);
        check("resume_score", 32'(score), 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
